// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_framer
//  Purpose  : UART transmitter for the serial console link. Bytes arrive on a
//             valid/ready stream, are buffered in a circular FIFO and sent
//             LSB-first as start + 8 data + optional parity + 1 or 2 stop
//             bits. The bit time is runtime-programmable (divisor + 1 cycles).
//  Ports    : clk, reset          - single clock, synchronous active-high reset
//             io_divisor          - cycles per bit minus one
//             io_parity_en/_odd   - parity enable / odd-parity select
//             io_stop2            - two stop bits when set
//             io_data_valid/ready/payload - byte input stream
//             io_tx               - registered serial line, idle high
//             io_busy             - frame in flight or bytes queued
//             io_fifo_level       - number of queued bytes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIV_WIDTH-1:0]        io_divisor,
  input  logic                        io_parity_en,
  input  logic                        io_parity_odd,
  input  logic                        io_stop2,
  input  logic                        io_data_valid,
  output logic                        io_data_ready,
  input  logic [7:0]                  io_data_payload,
  output logic                        io_tx,
  output logic                        io_busy,
  output logic [$clog2(FIFO_DEPTH):0] io_fifo_level
);

  localparam int              c_aw   = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_full = (c_aw + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q,    state_d;
  logic [c_aw-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [c_aw-1:0]       rd_ptr_q,   rd_ptr_d;
  logic [c_aw:0]         level_q,    level_d;
  logic [7:0]            shift_q,    shift_d;
  logic [2:0]            bit_idx_q,  bit_idx_d;
  logic [DIV_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [DIV_WIDTH-1:0]  div_q,      div_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_bit_q,  par_bit_d;
  logic                  stop2_q,    stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q,       tx_d;

  logic [7:0]            mem_q [FIFO_DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_empty;
  logic [7:0]            w_head;

  assign w_empty       = (level_q == '0);
  assign w_head        = mem_q[rd_ptr_q];
  assign w_push        = io_data_valid && io_data_ready;

  assign io_data_ready = (level_q != c_full);
  assign io_fifo_level = level_q;
  assign io_tx         = tx_q;
  assign io_busy       = (state_q != S_IDLE) || !w_empty;

  // FIFO storage; no reset needed, the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= io_data_payload;
    end
  end

  // FIFO pointer and occupancy next-state. Pointers wrap naturally because
  // the depth is a power of two.
  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Framer next-state. Each bit lasts until cnt_q reaches zero; cnt_q is
  // reloaded with the latched divisor at every bit boundary. The value of
  // io_tx for the next bit is computed at the boundary so the line is
  // always driven straight from a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    w_pop      = 1'b0;
    w_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!w_empty) begin
          w_load = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d      = div_q;
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == '0) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = div_q;
          end else if (!w_empty) begin
            // Chain straight into the next start bit with no idle gap.
            w_load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and freeze the line configuration so
    // config changes mid-frame only affect the following frame.
    if (w_load) begin
      w_pop      = 1'b1;
      shift_d    = w_head;
      div_d      = io_divisor;
      cnt_d      = io_divisor;
      par_en_d   = io_parity_en;
      par_bit_d  = (^w_head) ^ io_parity_odd;
      stop2_d    = io_stop2;
      stop_idx_d = 1'b0;
      bit_idx_d  = '0;
      tx_d       = 1'b0;
      state_d    = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
# uart_tx_framer

Synthesizable UART transmitter: the transmit side of the SoC's serial console link. It uses the same framing the console receiver and the simulation bench expect: LSB-first, 8 data bits, optional parity, 1 or 2 stop bits. The block sits between the peripheral bus (byte stream in, through an internal FIFO) and the `io_uart_tx` pad. Baud rate is runtime-programmable through a clock divisor.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: transmit FIFO entries; power of two, ≥2.
- `DIV_WIDTH`, 16: width of the divisor register.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `io_divisor`  in  DIV_WIDTH  cycles per bit minus 1 (bit time = divisor+1 cycles).
- `io_parity_en`  in  1  1 = append parity bit.
- `io_parity_odd`  in  1  0 = even parity (bit = ^data), 1 = odd parity.
- `io_stop2`  in  1  1 = two stop bits.
- `io_data_valid`  in  1  input byte valid.
- `io_data_ready`  out  1  FIFO can accept a byte.
- `io_data_payload`  in  8  byte to send.
- `io_tx`  out  1  serial line, idle high, registered.
- `io_busy`  out  1  frame in progress or FIFO non-empty.
- `io_fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

## Operation
- Byte accepted on a rising edge with `io_data_valid && io_data_ready`. `io_data_ready = (level != FIFO_DEPTH)`, combinational from FIFO state only.
- FIFO: circular buffer with read and write pointers. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the level unchanged. Push when full is impossible because ready is low.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `io_tx`=1. If FIFO non-empty: pop into shift register, latch divisor/parity/stop config, set `io_tx`=0, go to START.
  - START → DATA after one bit time. DATA shifts out bit0..bit7, one per bit time.
  - After bit7: go to PARITY if parity enabled, else STOP.
  - PARITY drives `^data ^ io_parity_odd`.
  - STOP drives 1 for 1 or 2 bit times.
  - At the end of STOP: if FIFO is non-empty, pop and go straight to START (no idle bit). Otherwise go to IDLE.
- Bit counter: down-counter loaded with the latched divisor at every bit boundary; a bit ends when it reaches 0.
- Config inputs are sampled only at frame start. Changes mid-frame take effect at the next frame.
- Frame length in bits: 10 + parity_en + stop2.
- `io_busy` = (state != IDLE) || (level != 0).

## Timing
- Reset values: `io_tx`=1, state IDLE, FIFO empty, `io_fifo_level`=0, `io_data_ready`=1, `io_busy`=0, shift and bit counters 0.
- Reset asserted mid-frame: on the next edge, `io_tx`=1 and the FIFO is flushed. The partial frame is abandoned; no completion is emitted.
- Latency: byte accepted at edge N into an idle, empty block → `io_tx` goes low after edge N+1.
- Every bit, including start, lasts exactly divisor+1 cycles. With divisor=0, one bit per cycle.
- Back-to-back frames: the next start bit follows the last stop bit's final cycle with no gap.
- `io_fifo_level` updates the edge after push/pop. A pop at frame start frees a slot the following cycle.
- `io_tx` changes only at bit boundaries; no glitches (driven from a flop).

## Test plan
- Divisor=3, even parity, 1 stop; send 0x55 → `io_tx` sequence 0,1,0,1,0,1,0,1,0,0,1, each held exactly 4 cycles; start bit falls 1 cycle after accept; `io_busy` drops after 44 cycles of frame.
- Divisor=0, odd parity, 2 stops; send 0x01 then 0x80 back-to-back → bits 0,1,0000000,0,1,1 then 0,0000000,1,0,1,1; no idle cycle between frames.
- Parity off, 1 stop, divisor=1; hold valid for 18 bytes while the first frame is running → 17 bytes accepted (1 popped + 16 queued); ready low with level=16; all 17 transmitted in order; level returns to 0.
- Change `io_divisor` from 3 to 7 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Assert `reset` for 1 cycle during DATA with 5 bytes queued → `io_tx`=1 and level=0 the next cycle; nothing further transmitted; a new byte afterwards starts a clean frame.
- Loopback: feed `io_tx` into the SoC console receiver at 24 Mbaud, 8E1 → 256 bytes 0x00..0xFF received intact with no parity or framing errors.
